// File: rtl/axis_i2s_pkg.sv
// Shared sizing and types for the AXI-Stream to 8-lane I2S playback path.
package axis_i2s_pkg;

    localparam int DATA_W     = 32;
    localparam int LANES      = 8;
    localparam int TDATA_W    = 128;
    localparam int BEATS      = LANES * DATA_W / TDATA_W;
    localparam int FRAME_BITS = 2 * DATA_W;
    localparam int CNT_W      = 6;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    typedef enum logic {
        BEAT_LO,
        BEAT_HI
    } beat_e;

endpackage

// File: rtl/axis_frame_assembler.sv
// Collects two AXI-Stream beats into one 8-lane frame and holds it until the
// serializer takes it at a frame boundary; misaligned tlast is flagged sticky.
module axis_frame_assembler #(
    parameter int DATA_W  = axis_i2s_pkg::DATA_W,
    parameter int LANES   = axis_i2s_pkg::LANES,
    parameter int TDATA_W = axis_i2s_pkg::TDATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TDATA_W-1:0]      tdata,
    input  logic                    tvalid,
    input  logic                    tlast,
    output logic                    tready,
    input  logic                    load,
    output logic [LANES*DATA_W-1:0] asm_frame,
    output logic                    frame_ready,
    output logic                    framing_err
);
    import axis_i2s_pkg::*;

    beat_e              beat_q, beat_d;
    logic               ready_d, err_d, wr_lo, wr_hi, accept;
    logic [TDATA_W-1:0] asm_lo_q, asm_hi_q;

    assign tready    = ~frame_ready;
    assign accept    = tvalid & ~frame_ready;
    assign asm_frame = {asm_hi_q, asm_lo_q};

    always_comb begin
        beat_d  = beat_q;
        ready_d = frame_ready;
        err_d   = framing_err;
        wr_lo   = 1'b0;
        wr_hi   = 1'b0;
        // load only fires while frame_ready is set, so it never meets an accept
        if (load) ready_d = 1'b0;
        if (accept) begin
            case (beat_q)
                BEAT_LO: begin
                    if (tlast) begin
                        err_d = 1'b1;
                    end else begin
                        wr_lo  = 1'b1;
                        beat_d = BEAT_HI;
                    end
                end
                BEAT_HI: begin
                    beat_d = BEAT_LO;
                    if (tlast) begin
                        wr_hi   = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q      <= BEAT_LO;
            frame_ready <= 1'b0;
            framing_err <= 1'b0;
            asm_lo_q    <= '0;
            asm_hi_q    <= '0;
        end else begin
            beat_q      <= beat_d;
            frame_ready <= ready_d;
            framing_err <= err_d;
            if (wr_lo) asm_lo_q <= tdata;
            if (wr_hi) asm_hi_q <= tdata;
        end
    end

endmodule

// File: rtl/axis_i2s_tx.sv
// AXI-Stream slave to 8 parallel I2S lanes, word-select master; each lane's
// sample goes in the left slot with the standard one-bit delay, right slot zero.
module axis_i2s_tx #(
    parameter int DATA_W  = axis_i2s_pkg::DATA_W,
    parameter int LANES   = axis_i2s_pkg::LANES,
    parameter int TDATA_W = axis_i2s_pkg::TDATA_W,
    parameter int UCNT_W  = 16
) (
    input  logic               sck,
    input  logic               rst,
    input  logic               start,
    input  logic [TDATA_W-1:0] S_AXIS_tdata,
    input  logic               S_AXIS_tvalid,
    input  logic               S_AXIS_tlast,
    output logic               S_AXIS_tready,
    output logic               ws,
    output logic [LANES-1:0]   sd,
    output logic [UCNT_W-1:0]  underrun_cnt,
    output logic               framing_err
);
    import axis_i2s_pkg::*;

    localparam int FRAME_W = LANES * DATA_W;
    localparam int IDX_W   = $clog2(DATA_W);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d, asm_frame;
    logic [UCNT_W-1:0]  ucnt_d;
    logic [LANES-1:0]   sd_d;
    logic               frame_ready, boundary, load, ws_d;

    // Slot position 1..DATA_W carries the sample MSB-first; everything else is zero.
    function automatic logic slot_bit(input logic [DATA_W-1:0] word,
                                      input logic [CNT_W-1:0]  cnt);
        logic [CNT_W-1:0] off;
        off = CNT_W'(DATA_W) - cnt;
        if (cnt >= CNT_W'(1) && cnt <= CNT_W'(DATA_W)) return word[off[IDX_W-1:0]];
        return 1'b0;
    endfunction

    axis_frame_assembler #(
        .DATA_W  (DATA_W),
        .LANES   (LANES),
        .TDATA_W (TDATA_W)
    ) u_asm (
        .clk         (sck),
        .rst         (rst),
        .tdata       (S_AXIS_tdata),
        .tvalid      (S_AXIS_tvalid),
        .tlast       (S_AXIS_tlast),
        .tready      (S_AXIS_tready),
        .load        (load),
        .asm_frame   (asm_frame),
        .frame_ready (frame_ready),
        .framing_err (framing_err)
    );

    always_comb begin
        boundary = start && (cnt_q == CNT_LAST);
        load     = boundary && frame_ready;
        cnt_d    = cnt_q + 1'b1;
        shadow_d = shadow_q;
        ucnt_d   = underrun_cnt;
        if (!start) begin
            cnt_d    = CNT_LAST;
            shadow_d = '0;
        end else if (boundary) begin
            cnt_d = '0;
            if (frame_ready) begin
                shadow_d = asm_frame;
            end else begin
                shadow_d = '0;
                if (underrun_cnt != '1) ucnt_d = underrun_cnt + 1'b1;
            end
        end
        ws_d = start & cnt_d[CNT_W-1];
    end

    // Outputs are registered from next-state values so they track cnt in the same cycle.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign sd_d[g] = start & slot_bit(shadow_d[g*DATA_W +: DATA_W], cnt_d);
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            cnt_q        <= CNT_LAST;
            shadow_q     <= '0;
            underrun_cnt <= '0;
            ws           <= 1'b0;
            sd           <= '0;
        end else begin
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            underrun_cnt <= ucnt_d;
            ws           <= ws_d;
            sd           <= sd_d;
        end
    end

endmodule
